alu_div_sequencer: RTL

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU that borrows the shared ALU and drives its SUB operation once per iteration, using the ALU carry flag as the restoring-division compare. It sits beside the execute stage. While the sequencer owns the ALU, `alu_sel_o` steers the execute-stage ALU operand mux to it. The pipeline stalls on `busy_o` and captures `result_o` on `done_o`.

---
 rtl/alu_div_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_div_sequencer.sv
// ============================================================================
// Module   : alu_div_sequencer
// Brief    : RV32M DIV/DIVU/REM/REMU restoring divider that borrows the ALU.
//            It drives one shared-ALU SUB per iteration and uses the carry
//            flag as the compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div_sequencer #(
  parameter int                    ALU_OP_W   = 4,
  // Must equal CONTROL_ALU_OP_SUB from core_defines.vh
  parameter logic [ALU_OP_W-1:0]   ALU_OP_SUB = ALU_OP_W'(1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [31:0]         dividend_i,
  input  logic [31:0]         divisor_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         result_o,
  output logic                alu_sel_o,
  output logic [31:0]         alu_a_o,
  output logic [31:0]         alu_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  input  logic [31:0]         alu_result_i,
  input  logic                alu_c_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_ovf;
  logic [32:0] w_shift;
  logic        w_take;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  // op_i[0] = 0 selects the signed variants (DIV/REM)
  assign w_signed = ~op_i[0];
  assign w_a_neg  = w_signed & dividend_i[31];
  assign w_b_neg  = w_signed & divisor_i[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - dividend_i) : dividend_i;
  assign w_b_mag  = w_b_neg ? (32'd0 - divisor_i) : divisor_i;
  assign w_ovf    = w_signed & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF);

  // A set bit 32 means S >= 2^32 > D, so the wrapped ALU difference is exact
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_take   = alu_c_i | w_shift[32];

  assign w_q_fin  = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fin  = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_div    <= 32'd0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (divisor_i == 32'd0) begin
              r_result <= op_i[1] ? dividend_i : 32'hFFFF_FFFF;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= op_i[1] ? 32'd0 : 32'h8000_0000;
              r_state  <= S_DONE;
            end else begin
              r_op    <= op_i;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_rem   <= 32'd0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= 5'd31;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_rem <= w_take ? alu_result_i : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_take};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= r_op[1] ? w_r_fin : w_q_fin;
          r_state  <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign alu_sel_o = (r_state == S_ITER);
  assign result_o  = r_result;
  assign alu_a_o   = alu_sel_o ? w_shift[31:0] : 32'd0;
  assign alu_b_o   = alu_sel_o ? r_div : 32'd0;
  assign alu_op_o  = alu_sel_o ? ALU_OP_SUB : '0;

endmodule

`default_nettype wire
